// File: rtl/mutative_flush_ctrl.sv
// Mode-level controller for the mutative cache: up steps are immediate, down steps walk every set to write back and invalidate.
// Latency: up / down-at-zero complete next cycle; a walk takes 2*SETS cycles plus 1 per occupied set plus (dfp latency+1) per dirty line.
// Backpressure: req_ready is low for the whole walk; each DFP write is held until dfp_resp, which stalls the walk in place.
module mutative_flush_ctrl #(
  parameter int WAYS      = 4,
  parameter int SETS      = 16,
  parameter int LINE_BITS = 256,
  parameter int TAG_BITS  = 23,
  parameter int ADDR_BITS = 32,
  parameter int MODE_MAX  = 3,
  localparam int SET_BITS    = $clog2(SETS),
  localparam int OFFSET_BITS = $clog2(LINE_BITS / 8),
  localparam int MODE_W      = $clog2(MODE_MAX + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_dir,
  output logic [MODE_W-1:0]         mode,
  output logic                      flush_stall,
  output logic                      done,
  output logic                      arr_rd_en,
  output logic [SET_BITS-1:0]       arr_set,
  input  logic [WAYS-1:0]           rd_valid,
  input  logic [WAYS-1:0]           rd_dirty,
  input  logic [WAYS*TAG_BITS-1:0]  rd_tag,
  input  logic [WAYS*LINE_BITS-1:0] rd_data,
  output logic                      inv_en,
  output logic [WAYS-1:0]           inv_way_mask,
  output logic                      dfp_write,
  output logic [ADDR_BITS-1:0]      dfp_addr,
  output logic [LINE_BITS-1:0]      dfp_wdata,
  input  logic                      dfp_resp,
  output logic [15:0]               wb_count
);

  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [2:0] {IDLE, READ, CHECK, WRITE, INV, DONE} state_t;

  state_t                     state_q, state_d;
  logic [SET_BITS-1:0]        set_ctr;
  logic [WAYS-1:0]            pend_q;
  logic [WAYS-1:0]            vmask_q;
  logic [WAYS*TAG_BITS-1:0]   tag_q;
  logic [WAYS*LINE_BITS-1:0]  data_q;
  logic                       done_q;
  logic [WAY_W-1:0]           way_sel;
  logic [WAYS-1:0]            way_bit;
  logic                       last_set;

  assign last_set = (set_ctr == SET_BITS'(SETS - 1));
  // Lowest pending way is written first; way_bit is its one-hot form.
  assign way_bit  = pend_q & (~pend_q + 1'b1);
  // Walk completion pulses from DONE; immediate completions use the registered pulse.
  assign done     = done_q | (state_q == DONE);

  // Encode the lowest pending way as an index for the tag/data part-selects.
  always_comb begin
    way_sel = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (pend_q[i]) way_sel = WAY_W'(i);
    end
  end

  // Next-state and strobe decode; every output defaults to 0 outside its state.
  always_comb begin
    state_d      = state_q;
    req_ready    = 1'b0;
    arr_rd_en    = 1'b0;
    arr_set      = '0;
    inv_en       = 1'b0;
    inv_way_mask = '0;
    dfp_write    = 1'b0;
    dfp_addr     = '0;
    dfp_wdata    = '0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid && !req_dir && (mode != '0)) state_d = READ;
      end
      READ: begin
        arr_rd_en = 1'b1;
        arr_set   = set_ctr;
        state_d   = CHECK;
      end
      CHECK: begin
        if ((rd_valid & rd_dirty) != '0) state_d = WRITE;
        else if (rd_valid != '0)         state_d = INV;
        else if (last_set)               state_d = DONE;
        else                             state_d = READ;
      end
      WRITE: begin
        dfp_write = 1'b1;
        dfp_addr  = {tag_q[int'(way_sel)*TAG_BITS +: TAG_BITS], set_ctr, {OFFSET_BITS{1'b0}}};
        dfp_wdata = data_q[int'(way_sel)*LINE_BITS +: LINE_BITS];
        if (dfp_resp && ((pend_q & ~way_bit) == '0)) state_d = INV;
      end
      INV: begin
        inv_en       = 1'b1;
        arr_set      = set_ctr;
        inv_way_mask = vmask_q;
        state_d      = last_set ? DONE : READ;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset aborts any walk in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Mode, stall, counters and per-set bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode        <= '0;
      flush_stall <= 1'b0;
      done_q      <= 1'b0;
      wb_count    <= '0;
      set_ctr     <= '0;
      pend_q      <= '0;
      vmask_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            if (req_dir) begin
              if (mode != MODE_W'(MODE_MAX)) mode <= mode + 1'b1;
              done_q <= 1'b1;
            end else if (mode == '0) begin
              done_q <= 1'b1;
            end else begin
              set_ctr     <= '0;
              wb_count    <= '0;
              flush_stall <= 1'b1;
            end
          end
        end
        CHECK: begin
          pend_q  <= rd_valid & rd_dirty;
          vmask_q <= rd_valid;
          if (state_d == READ) set_ctr <= set_ctr + 1'b1;
        end
        WRITE: begin
          if (dfp_resp) begin
            pend_q <= pend_q & ~way_bit;
            if (wb_count != 16'hFFFF) wb_count <= wb_count + 16'd1;
          end
        end
        INV: begin
          if (state_d == READ) set_ctr <= set_ctr + 1'b1;
        end
        DONE: begin
          mode        <= mode - 1'b1;
          flush_stall <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Tag and line capture of the set just read; only consumed while pending bits are set.
  always_ff @(posedge clk) begin
    if (state_q == CHECK) begin
      tag_q  <= rd_tag;
      data_q <= rd_data;
    end
  end

endmodule

// File: tb/tb_mutative_flush_ctrl.sv
module tb_mutative_flush_ctrl;
  localparam int WAYS = 4;
  localparam int SETS = 16;
  localparam int LB   = 256;
  localparam int TB   = 23;

  logic            clk = 1'b0;
  logic            rst;
  logic            req_valid, req_ready, req_dir;
  logic [1:0]      mode;
  logic            flush_stall, done, arr_rd_en;
  logic [3:0]      arr_set;
  logic [WAYS-1:0] rd_valid, rd_dirty;
  logic [WAYS*TB-1:0] rd_tag;
  logic [WAYS*LB-1:0] rd_data;
  logic            inv_en;
  logic [WAYS-1:0] inv_way_mask;
  logic            dfp_write;
  logic [31:0]     dfp_addr;
  logic [LB-1:0]   dfp_wdata;
  logic            dfp_resp;
  logic [15:0]     wb_count;

  mutative_flush_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_dir(req_dir),
    .mode(mode), .flush_stall(flush_stall), .done(done), .arr_rd_en(arr_rd_en), .arr_set(arr_set),
    .rd_valid(rd_valid), .rd_dirty(rd_dirty), .rd_tag(rd_tag), .rd_data(rd_data),
    .inv_en(inv_en), .inv_way_mask(inv_way_mask), .dfp_write(dfp_write), .dfp_addr(dfp_addr),
    .dfp_wdata(dfp_wdata), .dfp_resp(dfp_resp), .wb_count(wb_count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic [LB-1:0] data; } wr_t;
  typedef struct { logic [3:0] set; logic [3:0] mask; } inv_t;
  typedef struct { int cyc; logic [1:0] mode; logic [15:0] wb; bit walk; } dn_t;

  wr_t  wr_q[$];
  inv_t inv_q[$];
  dn_t  dn_q[$];
  int   lat_q[$];

  // Cache array contents seen by the controller.
  bit            mv[SETS][WAYS];
  bit            md[SETS][WAYS];
  logic [TB-1:0] mt[SETS][WAYS];
  logic [LB-1:0] mdat[SETS][WAYS];

  int errors = 0, checks = 0;
  int cyc = 0, done_seen = 0, exp_rd_set = 0;
  int m_mode = 0, m_wb = 0, force_lat = -1;
  bit exp_stall = 0, tie_resp = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [LB-1:0] act, input logic [LB-1:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, want);
    end
  endtask

  task automatic fail_msg(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: got no matching event, expected one", nm);
  endtask

  // Array model: reads return next cycle, invalidates clear valid and dirty.
  always @(posedge clk) begin : mem
    bit rq, iq;
    logic [3:0] sq, mq;
    rq = arr_rd_en; iq = inv_en; sq = arr_set; mq = inv_way_mask;
    #1;
    if (iq) for (int w = 0; w < WAYS; w++) if (mq[w]) begin mv[sq][w] = 0; md[sq][w] = 0; end
    if (rq) for (int w = 0; w < WAYS; w++) begin
      rd_valid[w] = mv[sq][w];
      rd_dirty[w] = md[sq][w];
      rd_tag[w*TB +: TB] = mt[sq][w];
      rd_data[w*LB +: LB] = mdat[sq][w];
    end
  end

  // DFP responder: answers each write after its scheduled latency (0 = first cycle).
  always @(posedge clk) begin : dfp
    int wcnt, cur_lat;
    bit have_lat;
    #1;
    if (!rst) begin
      dfp_resp = 0; have_lat = 0;
    end else begin
      if (dfp_resp) have_lat = 0;
      if (tie_resp) dfp_resp = 1;
      else if (dfp_write) begin
        if (!have_lat) begin
          cur_lat = (lat_q.size() > 0) ? lat_q.pop_front() : 0;
          have_lat = 1; wcnt = 0;
        end
        if (wcnt >= cur_lat) dfp_resp = 1;
        else begin dfp_resp = 0; wcnt++; end
      end else dfp_resp = 0;
    end
  end

  // Monitor: pops expectations whenever the DUT presents an event.
  always @(negedge clk) begin : mon
    bit prev_wr, prev_resp, mchk;
    logic [31:0] prev_addr;
    logic [LB-1:0] prev_data;
    logic [1:0] mchk_mode;
    logic [15:0] mchk_wb;
    wr_t wr; inv_t iv; dn_t d;
    if (!rst) begin
      prev_wr = 0; mchk = 0;
    end else begin
      if (mchk) begin
        chk("mode_after_done", mode, mchk_mode);
        chk("wb_count_after_done", wb_count, mchk_wb);
        mchk = 0;
      end
      chk("flush_stall", flush_stall, exp_stall);
      chk("req_ready", req_ready, !exp_stall);
      if (arr_rd_en) begin
        chk("arr_set_read", arr_set, exp_rd_set);
        exp_rd_set = (exp_rd_set + 1) % SETS;
      end
      if (dfp_write && prev_wr && !prev_resp) begin
        chk("dfp_addr_stable", dfp_addr, prev_addr);
        chk("dfp_wdata_stable", dfp_wdata, prev_data);
      end
      if (dfp_write && dfp_resp) begin
        if (wr_q.size() == 0) fail_msg("dfp_write_unexpected");
        else begin
          wr = wr_q.pop_front();
          chk("dfp_addr", dfp_addr, wr.addr);
          chk("dfp_wdata", dfp_wdata, wr.data);
        end
      end
      if (inv_en) begin
        if (inv_q.size() == 0) fail_msg("inv_unexpected");
        else begin
          iv = inv_q.pop_front();
          chk("inv_set", arr_set, iv.set);
          chk("inv_way_mask", inv_way_mask, iv.mask);
        end
      end
      if (done) begin
        if (dn_q.size() == 0) fail_msg("done_unexpected");
        else begin
          d = dn_q.pop_front();
          chk("done_cycle", cyc, d.cyc);
          mchk = 1; mchk_mode = d.mode; mchk_wb = d.wb;
          if (d.walk) begin
            chk("walk_leftover_writes", wr_q.size(), 0);
            chk("walk_leftover_invs", inv_q.size(), 0);
          end
        end
        exp_stall = 0;
        done_seen++;
      end
      prev_wr = dfp_write; prev_resp = dfp_resp; prev_addr = dfp_addr; prev_data = dfp_wdata;
    end
  end

  // Reference walk: per set, dirty valid lines in way order, then one invalidate if any valid.
  task automatic model_walk(output int e, output int wbn);
    wr_t wr; inv_t iv; int lat; logic [3:0] mask;
    e = 0; wbn = 0;
    for (int s = 0; s < SETS; s++) begin
      mask = 0;
      for (int w = 0; w < WAYS; w++) if (mv[s][w]) begin
        mask[w] = 1'b1;
        if (md[s][w]) begin
          wr.addr = {mt[s][w], 4'(s), 5'd0};
          wr.data = mdat[s][w];
          wr_q.push_back(wr);
          if (tie_resp) lat = 0;
          else begin
            lat = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 3));
            lat_q.push_back(lat);
          end
          e += lat + 1;
          wbn++;
        end
      end
      if (mask != 0) begin iv.set = 4'(s); iv.mask = mask; inv_q.push_back(iv); e++; end
      e += 2;
    end
  endtask

  task automatic wait_done(input int start);
    for (int i = 0; i < 3000 && done_seen == start; i++) @(negedge clk);
    if (done_seen == start) fail_msg("done_timeout");
    @(negedge clk);
  endtask

  task automatic issue(input bit dir);
    int e, wbn, start;
    dn_t d;
    @(negedge clk);
    start = done_seen;
    e = 0; d.walk = 0;
    if (dir) begin
      if (m_mode < 3) m_mode++;
    end else if (m_mode != 0) begin
      model_walk(e, wbn);
      m_mode--; m_wb = wbn; d.walk = 1;
    end
    d.cyc = cyc + 1 + e; d.mode = 2'(m_mode); d.wb = 16'(m_wb);
    dn_q.push_back(d);
    req_valid = 1; req_dir = dir;
    @(posedge clk); #1;
    req_valid = 0; req_dir = 0;
    if (d.walk) begin exp_stall = 1; exp_rd_set = 0; end
    wait_done(start);
  endtask

  task automatic clear_mem();
    for (int s = 0; s < SETS; s++) for (int w = 0; w < WAYS; w++) begin
      mv[s][w] = 0; md[s][w] = 0; mt[s][w] = TB'($urandom);
      for (int k = 0; k < LB / 32; k++) mdat[s][w][k*32 +: 32] = $urandom;
    end
  endtask

  task automatic rand_mem();
    clear_mem();
    for (int s = 0; s < SETS; s++) for (int w = 0; w < WAYS; w++) begin
      mv[s][w] = ($urandom_range(0, 1) == 1);
      md[s][w] = mv[s][w] && ($urandom_range(0, 1) == 1);
    end
  endtask

  task automatic reset_checks();
    chk("rst_mode", mode, 0);
    chk("rst_flush_stall", flush_stall, 0);
    chk("rst_done", done, 0);
    chk("rst_wb_count", wb_count, 0);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_arr_rd_en", arr_rd_en, 0);
    chk("rst_inv_en", inv_en, 0);
    chk("rst_dfp_write", dfp_write, 0);
  endtask

  initial begin
    int e, wbn;
    rst = 0; req_valid = 0; req_dir = 0; dfp_resp = 0;
    rd_valid = 0; rd_dirty = 0; rd_tag = 0; rd_data = 0;
    clear_mem();
    #2;
    reset_checks();
    repeat (3) @(negedge clk);
    rst = 1;

    // Up x4 saturates at 3, then two clean walks (3 -> 2 -> 1).
    repeat (4) issue(1);
    issue(0);
    issue(0);

    // Set 5: way 1 dirty, way 3 clean-valid, DFP latency 3.
    clear_mem();
    mv[5][1] = 1; md[5][1] = 1; mt[5][1] = 23'h12345; mv[5][3] = 1;
    force_lat = 3;
    issue(0);
    force_lat = -1;

    // Set 15 fully dirty with dfp_resp tied high.
    issue(1);
    clear_mem();
    for (int w = 0; w < WAYS; w++) begin mv[15][w] = 1; md[15][w] = 1; end
    tie_resp = 1;
    issue(0);
    tie_resp = 0;

    // Down at mode 0: immediate completion.
    issue(0);

    // Random array contents and latencies.
    for (int r = 0; r < 6; r++) begin
      rand_mem();
      if ($urandom_range(0, 1) == 1) issue(1);
      issue(1);
      issue(0);
    end

    // Reset in the middle of a long write on set 7.
    issue(1);
    clear_mem();
    mv[7][0] = 1; md[7][0] = 1;
    force_lat = 20;
    @(negedge clk);
    model_walk(e, wbn);
    req_valid = 1; req_dir = 0;
    @(posedge clk); #1;
    req_valid = 0;
    exp_stall = 1; exp_rd_set = 0;
    for (int i = 0; i < 200 && !dfp_write; i++) @(negedge clk);
    chk("write_reached", dfp_write, 1);
    chk("write_set_index", dfp_addr[8:5], 7);
    rst = 0;
    #1;
    reset_checks();
    wr_q.delete(); inv_q.delete(); dn_q.delete(); lat_q.delete();
    exp_stall = 0; force_lat = -1; m_mode = 0; m_wb = 0; dfp_resp = 0;
    repeat (2) @(negedge clk);
    rst = 1;
    issue(1);
    issue(0);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
